// File: rtl/rf_spi_pkg.sv
// Shared types and constants for the SPI register-file responder.
package rf_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_TURN    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int unsigned SHORT_HDR_BITS = 32'd8;
    localparam int unsigned LONG_HDR_BITS  = 32'd12;
    localparam int unsigned TURN_BITS      = 32'd4;
    localparam int unsigned DATA_BITS      = 32'd8;

    localparam int          DEF_SHORT_DEPTH  = 32'sd64;
    localparam int          DEF_LONG_DEPTH   = 32'sd1024;
    localparam logic [5:0]  DEF_INTSTAT_ADDR = 6'h31;

    // Counter values on the last bit of each phase. The first header bit is
    // consumed in IDLE, so the HDR phase sees header length minus one bits.
    localparam logic [4:0] SHORT_HDR_LAST = 5'(SHORT_HDR_BITS - 32'd2);
    localparam logic [4:0] LONG_HDR_LAST  = 5'(LONG_HDR_BITS - 32'd2);
    localparam logic [4:0] TURN_LAST      = 5'(TURN_BITS - 32'd1);
    localparam logic [4:0] DATA_LAST      = 5'(DATA_BITS - 32'd1);

    // Address reported on the write strobe: short addresses zero-extended.
    function automatic logic [9:0] wr_addr_ext(input logic lng, input logic [9:0] a);
        logic [9:0] r;
        if (lng) begin
            r = a;
        end else begin
            r = {4'b0000, a[5:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_regfile.sv
// Short and long register arrays: combinational read, one posedge write port,
// asynchronous clear of every entry.
module rf_regfile
    import rf_spi_pkg::*;
#(
    parameter int SHORT_DEPTH = DEF_SHORT_DEPTH,
    parameter int LONG_DEPTH  = DEF_LONG_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_long,
    input  logic [9:0]           rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 we,
    input  logic                 wr_long,
    input  logic [9:0]           wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);

    localparam int SW = (SHORT_DEPTH > 1) ? $clog2(SHORT_DEPTH) : 1;
    localparam int LW = (LONG_DEPTH > 1) ? $clog2(LONG_DEPTH) : 1;

    logic [DATA_BITS-1:0] short_mem_r [SHORT_DEPTH];
    logic [DATA_BITS-1:0] long_mem_r  [LONG_DEPTH];

    // Addresses wrap modulo the array depth so no access falls off the end.
    function automatic logic [SW-1:0] short_idx(input logic [5:0] a);
        return SW'({26'd0, a} % 32'(SHORT_DEPTH));
    endfunction

    function automatic logic [LW-1:0] long_idx(input logic [9:0] a);
        return LW'({22'd0, a} % 32'(LONG_DEPTH));
    endfunction

    assign rd_data = rd_long ? long_mem_r[long_idx(rd_addr)]
                             : short_mem_r[short_idx(rd_addr[5:0])];

    // Short array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SHORT_DEPTH; i++) begin
                short_mem_r[i] <= 8'h00;
            end
        end else if (we && !wr_long) begin
            short_mem_r[short_idx(wr_addr[5:0])] <= wr_data;
        end
    end

    // Long array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LONG_DEPTH; i++) begin
                long_mem_r[i] <= 8'h00;
            end
        end else if (we && wr_long) begin
            long_mem_r[long_idx(wr_addr)] <= wr_data;
        end
    end

endmodule

// File: rtl/rf_spi_resp.sv
// SPI responder for a short/long address register file with an interrupt
// status register. sck is the clock; a frame is a cs-low burst of bits.
module rf_spi_resp
    import rf_spi_pkg::*;
#(
    parameter int         SHORT_DEPTH  = DEF_SHORT_DEPTH,
    parameter int         LONG_DEPTH   = DEF_LONG_DEPTH,
    parameter logic [5:0] INTSTAT_ADDR = DEF_INTSTAT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sdi,
    output logic       sdo,
    input  logic [7:0] evt_in,
    output logic       intr,
    output logic       wr_stb,
    output logic       wr_long,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    state_e     state_r;
    state_e     state_s;
    logic [4:0] cnt_r;
    logic       long_r;
    logic       wr_r;
    logic [9:0] addr_r;
    logic [7:0] shreg_r;
    logic       armed_r;
    logic [7:0] intstat_r;
    logic       wr_stb_r;
    logic       wr_long_r;
    logic [9:0] wr_addr_r;
    logic [7:0] wr_data_r;

    logic       hdr_last_s;
    logic       turn_last_s;
    logic       data_last_s;
    logic       rd_is_intstat_s;
    logic       commit_s;
    logic       mem_we_s;
    logic       clear_s;
    logic [7:0] mem_rdata_s;
    logic [7:0] rdata_s;
    logic [7:0] wdata_s;
    logic       enter_rd_s;
    logic       enter_wr_s;

    assign hdr_last_s      = (cnt_r == (long_r ? LONG_HDR_LAST : SHORT_HDR_LAST));
    assign turn_last_s     = (cnt_r == TURN_LAST);
    assign data_last_s     = (cnt_r == DATA_LAST);
    assign rd_is_intstat_s = !long_r && (addr_r[5:0] == INTSTAT_ADDR);
    assign rdata_s         = rd_is_intstat_s ? intstat_r : mem_rdata_s;
    assign wdata_s         = {shreg_r[6:0], sdi};
    assign commit_s        = (state_r == ST_WR_DATA) && !cs && data_last_s;
    // INTSTAT is not writable over the bus; the strobe still reports the write.
    assign mem_we_s        = commit_s && !rd_is_intstat_s;
    assign clear_s         = (state_r == ST_RD_DATA) && !cs && data_last_s && rd_is_intstat_s;
    assign enter_rd_s      = (state_s == ST_RD_DATA) && (state_r != ST_RD_DATA);
    assign enter_wr_s      = (state_s == ST_WR_DATA) && (state_r != ST_WR_DATA);

    assign sdo     = (state_r == ST_RD_DATA) ? shreg_r[7] : 1'b0;
    assign busy    = (state_r != ST_IDLE);
    assign intr    = |intstat_r;
    assign wr_stb  = wr_stb_r;
    assign wr_long = wr_long_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

    rf_regfile #(
        .SHORT_DEPTH (SHORT_DEPTH),
        .LONG_DEPTH  (LONG_DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rd_long (long_r),
        .rd_addr (addr_r),
        .rd_data (mem_rdata_s),
        .we      (mem_we_s),
        .wr_long (long_r),
        .wr_addr (addr_r),
        .wr_data (wdata_s)
    );

    // Next-state logic; cs high anywhere mid-frame abandons the frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!cs && armed_r) state_s = ST_HDR;
                else                state_s = ST_IDLE;
            end
            ST_HDR: begin
                if (cs) begin
                    state_s = ST_IDLE;
                end else if (hdr_last_s) begin
                    if (long_r)   state_s = ST_TURN;
                    else if (sdi) state_s = ST_WR_DATA;
                    else          state_s = ST_RD_DATA;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_TURN: begin
                if (cs) begin
                    state_s = ST_IDLE;
                end else if (turn_last_s) begin
                    if (wr_r) state_s = ST_WR_DATA;
                    else      state_s = ST_RD_DATA;
                end else begin
                    state_s = ST_TURN;
                end
            end
            ST_RD_DATA, ST_WR_DATA: begin
                if (cs)               state_s = ST_IDLE;
                else if (data_last_s) state_s = ST_DONE;
                else                  state_s = state_r;
            end
            ST_DONE: begin
                if (cs) state_s = ST_IDLE;
                else    state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Per-phase bit counter, cleared whenever a new state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 5'd0;
        end else if (state_s != state_r) begin
            cnt_r <= 5'd0;
        end else if (state_r inside {ST_HDR, ST_TURN, ST_RD_DATA, ST_WR_DATA}) begin
            cnt_r <= cnt_r + 5'd1;
        end
    end

    // Header capture: frame type, address bits and the W bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_r <= 1'b0;
            wr_r   <= 1'b0;
            addr_r <= 10'd0;
        end else if (state_r == ST_IDLE) begin
            addr_r <= 10'd0;
            if (!cs && armed_r) long_r <= sdi;
        end else if ((state_r == ST_HDR) && !cs) begin
            if (hdr_last_s) wr_r <= sdi;
            else            addr_r <= {addr_r[8:0], sdi};
        end
    end

    // Data shift register: loads read data on entry, shifts out on reads,
    // shifts in on writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= 8'h00;
        end else if (enter_rd_s) begin
            shreg_r <= rdata_s;
        end else if (enter_wr_s) begin
            shreg_r <= 8'h00;
        end else if (state_r == ST_RD_DATA) begin
            shreg_r <= {shreg_r[6:0], 1'b0};
        end else if ((state_r == ST_WR_DATA) && !cs) begin
            shreg_r <= wdata_s;
        end
    end

    // A new frame may only start after cs has been seen high, so a reset
    // landing mid-frame does not cause a misaligned restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) armed_r <= 1'b0;
        else     armed_r <= armed_r | cs;
    end

    // Interrupt status: sticky events, cleared by a completed read; new
    // events on the clearing cycle survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          intstat_r <= 8'h00;
        else if (clear_s) intstat_r <= evt_in;
        else              intstat_r <= intstat_r | evt_in;
    end

    // Registered write notification, one cycle after the final data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_stb_r  <= 1'b0;
            wr_long_r <= 1'b0;
            wr_addr_r <= 10'd0;
            wr_data_r <= 8'h00;
        end else begin
            wr_stb_r <= commit_s;
            if (commit_s) begin
                wr_long_r <= long_r;
                wr_addr_r <= wr_addr_ext(long_r, addr_r);
                wr_data_r <= wdata_s;
            end
        end
    end

endmodule

// File: tb/tb_rf_spi_resp.sv
// Directed self-checking bench for rf_spi_resp.
module tb_rf_spi_resp;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       sdi;
    logic       sdo;
    logic [7:0] evt_in;
    logic       intr;
    logic       wr_stb;
    logic       wr_long;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_checks;
    int n_fail;

    rf_spi_resp dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .sdi     (sdi),
        .sdo     (sdo),
        .evt_in  (evt_in),
        .intr    (intr),
        .wr_stb  (wr_stb),
        .wr_long (wr_long),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Drives one frame on negedges and collects what the responder showed.
    task automatic run_frame(input logic lng, input logic [9:0] a, input logic w,
                             input logic [7:0] d, input int cut, input int gap,
                             input int evt_at, input logic [7:0] evt_val,
                             output logic [7:0] rd, output logic other_sdo,
                             output int stbs, output logic s_long,
                             output logic [9:0] s_addr, output logic [7:0] s_data);
        logic [23:0] bits;
        int n;
        int hl;
        int ns;
        if (lng) begin
            bits = {1'b1, a, w, 4'b0000, d};
            n = 24;
            hl = 16;
        end else begin
            bits = {1'b0, a[5:0], w, d, 8'h00};
            n = 16;
            hl = 8;
        end
        ns = (cut > 0 && cut < n) ? cut : n;
        rd = 8'h00; other_sdo = 1'b0; stbs = 0;
        s_long = 1'b0; s_addr = 10'd0; s_data = 8'h00;
        for (int i = 0; i < ns; i++) begin
            @(negedge clk);
            if (i >= hl) rd = {rd[6:0], sdo};
            else         other_sdo = other_sdo | sdo;
            if (wr_stb) stbs++;
            cs = 1'b0;
            sdi = bits[23-i];
            evt_in = (i == evt_at) ? evt_val : 8'h00;
        end
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            other_sdo = other_sdo | sdo;
            if (wr_stb) begin
                stbs++;
                s_long = wr_long; s_addr = wr_addr; s_data = wr_data;
            end
            cs = 1'b1;
            sdi = 1'b0;
            evt_in = 8'h00;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL rst_sdo: got %b expected 0", sdo); end
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rst_intr: got %b expected 0", intr); end
        n_checks++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL rst_wr_stb: got %b expected 0", wr_stb); end
        n_checks++; if (wr_long !== 1'b0) begin n_fail++; $display("FAIL rst_wr_long: got %b expected 0", wr_long); end
        n_checks++; if (wr_addr !== 10'h000) begin n_fail++; $display("FAIL rst_wr_addr: got %h expected 000", wr_addr); end
        n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 00", wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_short_write_read();
        logic [7:0] rd; logic os; int stbs; logic sl; logic [9:0] sa; logic [7:0] sd;
        run_frame(1'b0, 10'h012, 1'b1, 8'hA5, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (stbs !== 1) begin n_fail++; $display("FAIL sw_stb_count: got %0d expected 1", stbs); end
        n_checks++; if (sl !== 1'b0) begin n_fail++; $display("FAIL sw_long: got %b expected 0", sl); end
        n_checks++; if (sa !== 10'h012) begin n_fail++; $display("FAIL sw_addr: got %h expected 012", sa); end
        n_checks++; if (sd !== 8'hA5) begin n_fail++; $display("FAIL sw_data: got %h expected a5", sd); end
        run_frame(1'b0, 10'h012, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL sr_data: got %h expected a5", rd); end
        n_checks++; if (os !== 1'b0) begin n_fail++; $display("FAIL sr_sdo_idle: got %b expected 0", os); end
        n_checks++; if (stbs !== 0) begin n_fail++; $display("FAIL sr_no_stb: got %0d expected 0", stbs); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sr_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_long();
        logic [7:0] rd; logic os; int stbs; logic sl; logic [9:0] sa; logic [7:0] sd;
        run_frame(1'b1, 10'h3FF, 1'b1, 8'h5C, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (stbs !== 1) begin n_fail++; $display("FAIL lw_stb_count: got %0d expected 1", stbs); end
        n_checks++; if (sl !== 1'b1) begin n_fail++; $display("FAIL lw_long: got %b expected 1", sl); end
        n_checks++; if (sa !== 10'h3FF) begin n_fail++; $display("FAIL lw_addr: got %h expected 3ff", sa); end
        n_checks++; if (sd !== 8'h5C) begin n_fail++; $display("FAIL lw_data: got %h expected 5c", sd); end
        run_frame(1'b1, 10'h3FF, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h5C) begin n_fail++; $display("FAIL lr_data_bits: got %h expected 5c", rd); end
        n_checks++; if (os !== 1'b0) begin n_fail++; $display("FAIL lr_sdo_hdr_turn: got %b expected 0", os); end
        run_frame(1'b0, 10'h03F, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL short_3f_untouched: got %h expected 00", rd); end
    endtask

    task automatic test_abort();
        logic [7:0] rd; logic os; int stbs; logic sl; logic [9:0] sa; logic [7:0] sd;
        run_frame(1'b0, 10'h005, 1'b1, 8'hFF, 11, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (stbs !== 0) begin n_fail++; $display("FAIL abort_no_stb: got %0d expected 0", stbs); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        run_frame(1'b0, 10'h005, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL abort_mem: got %h expected 00", rd); end
    endtask

    task automatic test_intstat();
        logic [7:0] rd; logic os; int stbs; logic sl; logic [9:0] sa; logic [7:0] sd;
        @(negedge clk); evt_in = 8'h04;
        @(negedge clk); evt_in = 8'h00;
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL int_set: got %b expected 1", intr); end
        run_frame(1'b0, 10'h031, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h04) begin n_fail++; $display("FAIL int_read: got %h expected 04", rd); end
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL int_cleared: got %b expected 0", intr); end
        run_frame(1'b0, 10'h031, 1'b1, 8'hFF, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (stbs !== 1) begin n_fail++; $display("FAIL int_wr_stb: got %0d expected 1", stbs); end
        n_checks++; if (sa !== 10'h031) begin n_fail++; $display("FAIL int_wr_addr: got %h expected 031", sa); end
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL int_wr_ignored: got %b expected 0", intr); end
        @(negedge clk); evt_in = 8'h04;
        @(negedge clk); evt_in = 8'h00;
        run_frame(1'b0, 10'h031, 1'b0, 8'h00, 0, 3, 15, 8'h01, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h04) begin n_fail++; $display("FAIL int_read2: got %h expected 04", rd); end
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL int_set_wins: got %b expected 1", intr); end
        run_frame(1'b0, 10'h031, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h01) begin n_fail++; $display("FAIL int_read3: got %h expected 01", rd); end
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL int_cleared2: got %b expected 0", intr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic os; int stbs; logic sl; logic [9:0] sa; logic [7:0] sd;
        run_frame(1'b0, 10'h020, 1'b1, 8'h11, 0, 1, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (sd !== 8'h11 || stbs !== 1) begin n_fail++; $display("FAIL b2b_w1: got data %h stb %0d expected 11 1", sd, stbs); end
        run_frame(1'b0, 10'h021, 1'b1, 8'h22, 0, 1, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (sd !== 8'h22 || sa !== 10'h021) begin n_fail++; $display("FAIL b2b_w2: got data %h addr %h expected 22 021", sd, sa); end
        run_frame(1'b0, 10'h020, 1'b0, 8'h00, 0, 1, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h11) begin n_fail++; $display("FAIL b2b_r1: got %h expected 11", rd); end
        run_frame(1'b0, 10'h021, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h22) begin n_fail++; $display("FAIL b2b_r2: got %h expected 22", rd); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] bits;
        logic [7:0] rd; logic os; int stbs; logic sl; logic [9:0] sa; logic [7:0] sd;
        bits = {1'b1, 10'h3FF, 1'b0, 4'b0000, 8'h00};
        @(negedge clk); evt_in = 8'h80;
        @(negedge clk); evt_in = 8'h00;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            cs = 1'b0;
            sdi = bits[23-i];
        end
        @(negedge clk);
        n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL rm_sdo_before: got %b expected 1", sdo); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL rm_intr_before: got %b expected 1", intr); end
        rst = 1'b1;
        #1;
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL rm_sdo: got %b expected 0", sdo); end
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rm_intr: got %b expected 0", intr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
        n_checks++; if (wr_addr !== 10'h000) begin n_fail++; $display("FAIL rm_wr_addr: got %h expected 000", wr_addr); end
        n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rm_wr_data: got %h expected 00", wr_data); end
        n_checks++; if (wr_stb !== 1'b0 || wr_long !== 1'b0) begin n_fail++; $display("FAIL rm_wr_flags: got %b%b expected 00", wr_stb, wr_long); end
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sdi = ~sdi;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_no_resync_low: got %b expected 0", busy); end
        @(negedge clk); cs = 1'b1;
        run_frame(1'b0, 10'h000, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h00 || os !== 1'b0) begin n_fail++; $display("FAIL rm_read_00: got %h/%b expected 00/0", rd, os); end
        run_frame(1'b0, 10'h012, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rm_mem_cleared_short: got %h expected 00", rd); end
        run_frame(1'b1, 10'h3FF, 1'b0, 8'h00, 0, 3, -1, 8'h00, rd, os, stbs, sl, sa, sd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rm_mem_cleared_long: got %h expected 00", rd); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        cs = 1'b1;
        sdi = 1'b0;
        evt_in = 8'h00;
        n_checks = 0;
        n_fail = 0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        test_short_write_read();
        test_long();
        test_abort();
        test_intstat();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
